aes_sbox: RTL and testbench
===========================

// Module: aes_sbox
// PURPOSE
//   AES (FIPS-197) byte-substitution lookup for one byte. The byte is presented as two
//   nibbles: row (high) and col (low). The block returns the S-box entry, registered.
//   Sixteen instances form the SubBytes / InvSubBytes stage of the AES-128 round
//   datapath.
// PARAMETERS
//   INVERSE   0   0 = forward S-box (SubBytes); 1 = inverse S-box (InvSubBytes); elaboration-time only
// PORTS
//   clk       input   1  clock; rising-edge active
//   reset     input   1  asynchronous, active-low reset
//   row       input   4  high nibble of input byte (bits 7:4)
//   col       input   4  low nibble of input byte (bits 3:0)
//   out_byte  output  8  substituted byte, registered
// BEHAVIOUR
//   - Clocking and reset: reset is asynchronous and active-low; the clock is clk.
//   - Lookup index: idx = {row, col}, 8 bits, 0x00..0xFF. The lookup is a full
//     256-entry constant table.
//       - INVERSE=0: FIPS-197 Fig.7 forward S-box.
//       - INVERSE=1: FIPS-197 Fig.14 inverse S-box.
//     Every index is defined. There are no don't-care or default-X entries.
//   - Output register:
//       - reset low: out_byte = 8'h00 immediately, without waiting for a clock edge.
//       - reset high, rising clk edge: out_byte <= table[{row,col}].
//   - Latency: exactly 1 clk cycle from a row/col change to out_byte.
//     Throughput: one new byte per cycle; inputs may change every cycle.
//   - Reset mid-operation: out_byte drops to 8'h00 at once and stays there while reset
//     is low. On the first rising edge after reset is released, out_byte takes the
//     lookup of the current inputs. No other state exists.
//   - Reset value vs. data: the reset value 8'h00 is a valid table output.
//     Forward: S(0x52)=0x00. Inverse: InvS(0x63)=0x00.
//     Downstream logic must not treat 8'h00 as "idle".
//   - No enable and no handshake. The block is purely a table lookup followed by a
//     register.
//   - The registered lookup must synthesize to a LUT/ROM, with no latches.
// STRUCTURE
//   - Shared package aes_pkg:
//       - function aes_sbox_fwd(input [7:0]) returning [7:0]: 256-way case.
//       - function aes_sbox_inv(input [7:0]) returning [7:0]: 256-way case.
//     These let key-expansion and any other datapath reuse identical tables.
//   - aes_sbox selects one function by INVERSE with a generate-if, then adds the output
//     flop. No further sub-modules.
// TESTING
//   1. Reset: hold reset=0 with row/col=0x5,0x3 and toggle clk.
//      -> out_byte = 8'h00 throughout. Release reset; one edge later -> 8'hED.
//   2. Forward spot values (INVERSE=0), one per cycle, each 1 cycle after apply:
//      00->63, 01->7C, 10->CA, 21->FD, 53->ED, 52->00, FF->16.
//   3. Inverse spot values (INVERSE=1): 63->00, 00->52, ED->53, 16->FF, 7C->01.
//   4. Exhaustive sweep of idx 0..255, back-to-back:
//       - Compare each result against a golden model delayed by 1 cycle.
//       - Fwd and inv instances chained must reproduce idx (round-trip identity).
//       - The forward outputs must form a permutation: all 256 values distinct.
//   5. Async reset mid-stream: while streaming, pull reset low between clock edges.
//      -> out_byte = 00 before the next edge. Re-release -> stream resumes with
//         1-cycle latency.
//   6. Pipeline check: change row/col every cycle with pattern 0x01,0x02,0x03.
//      -> out_byte = 7C,77,7B on the following three edges.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared FIPS-197 forward and inverse S-box tables as 256-way lookup functions
package aes_pkg;

    function automatic logic [7:0] aes_sbox_fwd(input logic [7:0] x);
        logic [7:0] s;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] aes_sbox_inv(input logic [7:0] x);
        logic [7:0] s;
        case (x)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: registered AES S-box lookup of {row, col}; INVERSE selects SubBytes or InvSubBytes
module aes_sbox
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] out_byte
);
    logic [7:0] lut;

    generate
        if (INVERSE) begin : g_inv
            assign lut = aes_sbox_inv({row, col});
        end else begin : g_fwd
            assign lut = aes_sbox_fwd({row, col});
        end
    endgenerate

    // output flop; 8'h00 on reset is also a legitimate table value, not an idle marker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_byte <= 8'h00;
        else out_byte <= lut;
    end
endmodule

// File: tb/tb_aes_sbox.sv
// tb_aes_sbox: directed and exhaustive checks of forward, inverse and chained S-box instances
module tb_aes_sbox;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row = 4'h0, col = 4'h0, irow = 4'h0, icol = 4'h0;
    logic [7:0] fwd_out, inv_out, rt_out;
    int         n_checks = 0, n_errors = 0, distinct = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    bit         seen [256];
    logic [15:0] fwd_vec [7] = '{16'h0063, 16'h017c, 16'h10ca, 16'h21fd, 16'h53ed, 16'h5200, 16'hff16};
    logic [15:0] inv_vec [5] = '{16'h6300, 16'h0052, 16'hed53, 16'h16ff, 16'h7c01};
    logic [15:0] pipe_vec [3] = '{16'h017c, 16'h0277, 16'h037b};
    logic [7:0] v, b;

    always #5 clk = ~clk;

    aes_sbox #(.INVERSE(1'b0)) u_fwd (.clk(clk), .reset(reset), .row(row), .col(col), .out_byte(fwd_out));
    aes_sbox #(.INVERSE(1'b1)) u_inv (.clk(clk), .reset(reset), .row(irow), .col(icol), .out_byte(inv_out));
    aes_sbox #(.INVERSE(1'b1)) u_rt (.clk(clk), .reset(reset), .row(fwd_out[7:4]), .col(fwd_out[3:0]), .out_byte(rt_out));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, used to build the golden model from first principles
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] mm = m;
        for (int i = 0; i < 8; i++) begin
            if (mm[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            mm = mm >> 1;
        end
        return p;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            b = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
            sb[x] = b;
            isb[b] = 8'(x);
        end

        row = 4'h5; col = 4'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold_fwd", {8'h00, fwd_out}, 16'h0000);
            check("reset_hold_inv", {8'h00, inv_out}, 16'h0000);
        end
        reset = 1'b1;
        step();
        check("reset_release", {8'h00, fwd_out}, 16'h00ed);

        foreach (fwd_vec[i]) begin
            {row, col} = fwd_vec[i][15:8];
            step();
            check("fwd_spot", {fwd_vec[i][15:8], fwd_out}, fwd_vec[i]);
        end

        foreach (inv_vec[i]) begin
            {irow, icol} = inv_vec[i][15:8];
            step();
            check("inv_spot", {inv_vec[i][15:8], inv_out}, inv_vec[i]);
        end

        for (int i = 0; i < 256; i++) begin
            {row, col} = 8'(i);
            {irow, icol} = 8'(i);
            step();
            check("sweep_fwd", {8'(i), fwd_out}, {8'(i), sb[i]});
            check("sweep_inv", {8'(i), inv_out}, {8'(i), isb[i]});
            if (i > 0) check("round_trip", {8'h00, rt_out}, 16'(i - 1));
            if (!seen[fwd_out]) begin
                seen[fwd_out] = 1'b1;
                distinct++;
            end
        end
        step();
        check("round_trip_last", {8'h00, rt_out}, 16'h00ff);
        check("permutation", 16'(distinct), 16'd256);

        for (int i = 0; i < 4; i++) begin
            {row, col} = 8'h10 + 8'(i);
            step();
            check("stream_pre_reset", {8'h00, fwd_out}, {8'h00, sb[8'h10 + i]});
        end
        #3 reset = 1'b0;
        #1;
        check("async_reset_fwd", {8'h00, fwd_out}, 16'h0000);
        check("async_reset_inv", {8'h00, inv_out}, 16'h0000);
        step();
        check("reset_low_edge", {8'h00, fwd_out}, 16'h0000);
        {row, col} = 8'h53;
        {irow, icol} = 8'hed;
        reset = 1'b1;
        step();
        check("resume_fwd", {8'h00, fwd_out}, 16'h00ed);
        check("resume_inv", {8'h00, inv_out}, 16'h0053);
        {row, col} = 8'h00;
        step();
        check("resume_next", {8'h00, fwd_out}, 16'h0063);

        foreach (pipe_vec[i]) begin
            {row, col} = pipe_vec[i][15:8];
            step();
            check("pipeline", {pipe_vec[i][15:8], fwd_out}, pipe_vec[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
